muldiv_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_div_core.sv | 38 +++
 rtl/muldiv_unit.sv | 157 +++++++++++++++
 tb/tb_muldiv_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared opcode/state types and decode helpers for the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// rtl/muldiv_div_core.sv - unsigned radix-2 restoring divider, one quotient bit per step
module muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   part;
    logic             ge;

    // q doubles as the dividend shift register; its MSB feeds the partial remainder
    assign part = {r, q[WIDTH-1]};
    assign ge   = part >= {1'b0, d};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
            r <= '0;
            d <= '0;
        end else if (load) begin
            q <= dividend;
            r <= '0;
            d <= divisor;
        end else if (step) begin
            r <= ge ? WIDTH'(part - {1'b0, d}) : part[WIDTH-1:0];
            q <= {q[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MULT/DIV unit owning HI/LO, with busy/done handshake
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_e             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               b_zero;
    logic [WIDTH-1:0]   a_saved;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;

    logic               sgn;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_now;
    logic [2*WIDTH-1:0] prod_now_signed;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   dq;
    logic [WIDTH-1:0]   dr;
    logic               div_load;
    logic               div_step;
    logic               last_iter;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    assign sgn             = op_is_signed(op);
    assign mag_a           = mag(a, sgn);
    assign mag_b           = mag(b, sgn);
    assign prod_now        = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    assign prod_now_signed = (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? -prod_now : prod_now;
    assign mul_sum         = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign last_iter       = (cnt == CW'(WIDTH - 1));
    assign div_load        = (state == IDLE) && start && !flush && op_is_div(op);
    assign div_step        = (state == DIV) && !flush;

    muldiv_div_core #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .step     (div_step),
        .dividend (mag_a),
        .divisor  (mag_b),
        .q        (dq),
        .r        (dr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            a_saved     <= '0;
            mcand       <= '0;
            prod        <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        div_by_zero <= 1'b0;
                        // operand signs are captured here; the iterative paths work on magnitudes
                        neg_q   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r   <= sgn & a[WIDTH-1];
                        b_zero  <= (b == '0);
                        a_saved <= a;
                        mcand   <= mag_a;
                        prod    <= {{WIDTH{1'b0}}, mag_b};
                        case (op)
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            OP_MULT, OP_MULTU: begin
                                if (MUL_ITER == 0) begin
                                    {hi, lo} <= prod_now_signed;
                                    done     <= 1'b1;
                                end else begin
                                    state  <= MUL;
                                    busy   <= 1'b1;
                                    is_div <= 1'b0;
                                end
                            end
                            OP_DIV, OP_DIVU: begin
                                state  <= DIV;
                                busy   <= 1'b1;
                                is_div <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    MUL: begin
                        prod  <= {mul_sum, prod[WIDTH-1:1]};
                        cnt   <= last_iter ? '0 : cnt + CW'(1);
                        if (last_iter) state <= FIX;
                    end
                    DIV: begin
                        cnt   <= last_iter ? '0 : cnt + CW'(1);
                        if (last_iter) state <= FIX;
                    end
                    FIX: begin
                        if (is_div) begin
                            if (b_zero) begin
                                lo          <= '1;
                                hi          <= a_saved;
                                div_by_zero <= 1'b1;
                            end else begin
                                lo <= neg_q ? -dq : dq;
                                hi <= neg_r ? -dr : dr;
                            end
                        end else begin
                            {hi, lo} <= neg_q ? -prod : prod;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench: two DUTs (single-cycle and iterative multiply) vs a behavioural model
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    op_e          op    = OP_MTHI;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;

    logic         busy0, done0, dbz0, busy1, done1, dbz1;
    logic [W-1:0] hi0, lo0, hi1, lo1;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .MUL_ITER(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy0), .done(done0), .div_by_zero(dbz0), .hi(hi0), .lo(lo0)
    );

    muldiv_unit #(.WIDTH(W), .MUL_ITER(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy1), .done(done1), .div_by_zero(dbz1), .hi(hi1), .lo(lo1)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // returns {div_by_zero, hi, lo} from plain arithmetic
    function automatic logic [2*W:0] ref_result(input op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint          sx, sy;
        longint unsigned p;
        logic [W-1:0]    qv, rv;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            OP_MULT:  begin p = sx * sy;                       return {1'b0, p}; end
            OP_MULTU: begin p = {32'd0, x} * {32'd0, y};       return {1'b0, p}; end
            OP_DIV: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
                qv = 32'(sx / sy);
                rv = 32'(sx % sy);
                return {1'b0, rv, qv};
            end
            OP_DIVU: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
            default: return '0;
        endcase
    endfunction

    logic [W-1:0]   m_hi [2], m_lo [2], p_hi [2], p_lo [2];
    logic           m_busy [2], m_done [2], m_dbz [2], p_dbz [2];
    int             m_cnt [2];
    logic [2*W:0]   m_r;

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_hi[k] = '0; m_lo[k] = '0; p_hi[k] = '0; p_lo[k] = '0;
                m_busy[k] = 1'b0; m_done[k] = 1'b0; m_dbz[k] = 1'b0; p_dbz[k] = 1'b0;
                m_cnt[k] = 0;
            end else begin
                m_done[k] = 1'b0;
                if (m_busy[k]) begin
                    if (flush) m_busy[k] = 1'b0;
                    else begin
                        m_cnt[k] = m_cnt[k] - 1;
                        if (m_cnt[k] == 0) begin
                            m_busy[k] = 1'b0;
                            m_done[k] = 1'b1;
                            m_hi[k]   = p_hi[k];
                            m_lo[k]   = p_lo[k];
                            m_dbz[k]  = p_dbz[k];
                        end
                    end
                end else if (start && !flush) begin
                    m_r      = ref_result(op, a, b);
                    m_dbz[k] = 1'b0;
                    case (op)
                        OP_MTHI: m_hi[k] = a;
                        OP_MTLO: m_lo[k] = a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            if (k == 0 && (op == OP_MULT || op == OP_MULTU)) begin
                                {m_hi[k], m_lo[k]} = m_r[2*W-1:0];
                                m_done[k] = 1'b1;
                            end else begin
                                {p_dbz[k], p_hi[k], p_lo[k]} = m_r;
                                m_cnt[k]  = LAT;
                                m_busy[k] = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy0", busy0, m_busy[0]);
            check("done0", done0, m_done[0]);
            check("dbz0",  dbz0,  m_dbz[0]);
            check("hi0",   hi0,   m_hi[0]);
            check("lo0",   lo0,   m_lo[0]);
            check("busy1", busy1, m_busy[1]);
            check("done1", done1, m_done[1]);
            check("dbz1",  dbz1,  m_dbz[1]);
            check("hi1",   hi1,   m_hi[1]);
            check("lo1",   lo1,   m_lo[1]);
        end
    end

    task automatic issue(input op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int k, output int nb);
        nb = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((k == 0) ? done0 : done1) return;
            if ((k == 0) ? busy0 : busy1) nb++;
        end
        checks++;
        errors++;
        $display("FAIL wait_done%0d: no done within 200 cycles, required done=1", k);
        nb = -1;
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    initial begin
        int nb;
        int seen;
        repeat (3) @(negedge clk);
        check("rst_hi0",   hi0,   0);
        check("rst_lo1",   lo1,   0);
        check("rst_busy1", busy1, 0);
        check("rst_done0", done0, 0);
        check("rst_dbz1",  dbz1,  0);
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;

        issue(OP_DIV, -32'sd7, 32'd2);
        wait_done(1, nb);
        check("div_latency", nb, 33);
        check("div_lo1", lo1, 32'hFFFF_FFFD);
        check("div_hi1", hi1, 32'hFFFF_FFFF);
        check("div_lo0", lo0, 32'hFFFF_FFFD);

        issue(OP_DIVU, 32'd100, 32'd0);
        wait_done(1, nb);
        check("dz_lo", lo1, 32'hFFFF_FFFF);
        check("dz_hi", hi1, 32'd100);
        check("dz_flag1", dbz1, 1);
        check("dz_flag0", dbz0, 1);
        issue(OP_MTLO, 32'd5, 32'd0);
        @(negedge clk);
        check("dz_clear", dbz1, 0);
        check("mtlo_lo", lo1, 32'd5);

        issue(OP_MULT, -32'sd3, 32'd5);
        @(negedge clk);
        check("mult0_done", done0, 1);
        check("mult0_busy", busy0, 0);
        check("mult0_hi", hi0, 32'hFFFF_FFFF);
        check("mult0_lo", lo0, 32'hFFFF_FFF1);
        wait_done(1, nb);
        check("mult1_latency", nb + 1, 33);
        check("mult1_hi", hi1, 32'hFFFF_FFFF);
        check("mult1_lo", lo1, 32'hFFFF_FFF1);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, nb);
        check("multu_latency", nb, 33);
        check("multu_hi1", hi1, 32'hFFFF_FFFE);
        check("multu_lo1", lo1, 32'h1);
        check("multu_hi0", hi0, 32'hFFFF_FFFE);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        issue(OP_MTHI, 32'h1234, 32'd0);
        wait_done(1, nb);
        check("ovf_lo", lo1, 32'h8000_0000);
        check("ovf_hi", hi1, 32'h0);

        issue(OP_MTHI, 32'hAAAA, 32'd0);
        issue(OP_MTLO, 32'h5555, 32'd0);
        issue(OP_DIVU, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy1", busy1, 0);
        check("flush_busy0", busy0, 0);
        check("flush_hi", hi1, 32'hAAAA);
        check("flush_lo", lo1, 32'h5555);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done1 || done0) seen++;
        end
        check("flush_nodone", seen, 0);

        @(negedge clk);
        #1;
        flush = 1'b1; start = 1'b1; op = OP_MTHI; a = 32'hDEAD;
        @(posedge clk);
        #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush_start_hi", hi1, 32'hAAAA);

        issue(OP_DIV, 32'd50, 32'd7);
        wait_done(1, nb);
        check("b2b_lo_a", lo1, 32'd7);
        check("b2b_hi_a", hi1, 32'd1);
        #1;
        start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b_busy", busy1, 1);
        wait_done(1, nb);
        check("b2b_lo_b", lo1, 32'd4);
        check("b2b_hi_b", hi1, 32'd1);

        repeat (3000) begin
            @(negedge clk);
            #1;
            start = ($urandom_range(0, 3) == 0);
            op    = op_e'($urandom_range(0, 5));
            a     = rand_val();
            b     = rand_val();
            flush = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        repeat (40) @(negedge clk);

        issue(OP_MTHI, 32'h77, 32'd0);
        issue(OP_DIV, 32'd12345, 32'd67);
        repeat (5) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("arst_hi1", hi1, 0);
        check("arst_lo1", lo1, 0);
        check("arst_busy1", busy1, 0);
        check("arst_hi0", hi0, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
